w_mem_responder: RTL and testbench
==================================

W_MEM_RESPONDER -- requirements
Module: w_mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set address width; memory depth SHALL be 2^ADDR_W words of 16 bits.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous and active-high.
REQ-004 MR  input  1  read request from the register bank (load W from memory).
REQ-005 MW  input  1  write request from the register bank (store W to memory).
REQ-006 Addr  input  ADDR_W  word address of the access.
REQ-007 W_MEM_OUT  input  16  write data; this is the register bank's W value.
REQ-008 W_MEM_IN  output  16  read data returned to the register bank.
REQ-009 Mem_Ready  output  1  high only in IDLE; the block accepts requests only while it is high.
REQ-010 Mem_Ack  output  1  one-cycle pulse marking completion of an access.
REQ-011 Mem_Error  output  1  one-cycle pulse on an illegal request.

Function
REQ-012 The FSM SHALL have four states: IDLE, WRITE, READ and DONE.
REQ-013 Mem_Ready SHALL be decoded combinationally from state==IDLE; all other outputs SHALL be registered.
REQ-014 IDLE, MW=1 and MR=0 at an edge: the block SHALL latch Addr and W_MEM_OUT and go to WRITE.
REQ-015 IDLE, MR=1 and MW=0 at an edge: the block SHALL latch Addr and go to READ.
REQ-016 IDLE, MR=1 and MW=1 at an edge: the block SHALL perform no access, stay in IDLE and assert Mem_Error for exactly the following cycle.
REQ-017 IDLE, MR=0 and MW=0: the block SHALL stay in IDLE with no effect.
REQ-018 WRITE: at the next edge, mem[latched addr] SHALL take the latched data, and the FSM SHALL go to DONE.
REQ-019 READ: at the next edge, W_MEM_IN SHALL take mem[latched addr], and the FSM SHALL go to DONE.
REQ-020 DONE: Mem_Ack SHALL be 1 for this one cycle; at the next edge the FSM SHALL return to IDLE.
REQ-021 Latency: for a request sampled at edge N, Mem_Ack SHALL be high in the cycle after edge N+1; Mem_Ready SHALL be high again after edge N+2.
REQ-022 MR, MW, Addr and W_MEM_OUT SHALL be ignored in WRITE, READ and DONE; data and address are those latched at acceptance.
REQ-023 Requesters SHALL deassert MR/MW in the Mem_Ack cycle; a request still held in the following IDLE cycle SHALL be treated as a new request.
REQ-024 W_MEM_IN SHALL hold its value until the next read completes; writes SHALL NOT change it (except as in REQ-029).
REQ-025 A read from an address SHALL return the data of the most recent completed write to that address; back-to-back write-then-read SHALL need no extra stall.
REQ-026 Address arithmetic SHALL use no wrap or offset; Addr maps directly to the word index, including 0 and 2^ADDR_W-1.

Reset
REQ-027 While reset is high: state=IDLE, W_MEM_IN=0, Mem_Ack=0, Mem_Error=0, Mem_Ready=1, and latched address and data = 0.
REQ-028 Reset asserted in WRITE SHALL abort the write, leave memory unchanged and suppress Mem_Ack; memory contents SHALL NOT be cleared by reset.

Configuration
REQ-029 With W_MEM_WRITE_THROUGH_EN defined, a completed write SHALL also load W_MEM_IN with the written data in the same edge as the memory update; without it, W_MEM_IN SHALL change only on reads.

Verification
REQ-030 Write 0xBEEF to Addr 0x12, then read 0x12 -> Mem_Ack each 2 cycles after acceptance; W_MEM_IN=0xBEEF during the read Ack cycle.
REQ-031 MR=MW=1 at Addr 0x05 in IDLE -> Mem_Error high 1 cycle, no Ack, mem[0x05] unchanged, FSM stays in IDLE.
REQ-032 Reset pulsed while in WRITE of 0x1234 to 0x20 (prior value 0xAAAA) -> read of 0x20 returns 0xAAAA; all outputs at reset values during reset.
REQ-033 MR held high through the Ack cycle at Addr 0xFF -> second read accepted in the next IDLE cycle; Addr 0xFF and 0x00 both accessible.
REQ-034 Write 0x5555 to 0x01 after a read returned 0x0F0F -> W_MEM_IN stays 0x0F0F without W_MEM_WRITE_THROUGH_EN, becomes 0x5555 with it.
REQ-035 Addr and W_MEM_OUT changed during WRITE (0x30/0x1111 -> 0x31/0x2222) -> mem[0x30]=0x1111 and mem[0x31] unchanged.

Source files
------------

// File: rtl/w_mem_responder.sv
// w_mem_responder: four-state single-port memory responder for a register bank's W value.
// Optional W_MEM_WRITE_THROUGH_EN: a completed write also loads W_MEM_IN with the written data.
module w_mem_responder #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MR,
  input  logic              MW,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [15:0]       W_MEM_OUT,
  output logic [15:0]       W_MEM_IN,
  output logic              Mem_Ready,
  output logic              Mem_Ack,
  output logic              Mem_Error
);
  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
  state_t state;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0] data_q;
  logic [15:0] mem [0:(1<<ADDR_W)-1];
  assign Mem_Ready = state == IDLE;
  // memory is never cleared; an async reset in WRITE has already left WRITE before the next edge
  always_ff @(posedge clk)
    if (state == WRITE && !reset) mem[addr_q] <= data_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      W_MEM_IN  <= '0;
      Mem_Ack   <= 1'b0;
      Mem_Error <= 1'b0;
    end else begin
      Mem_Ack   <= state == WRITE || state == READ;
      Mem_Error <= state == IDLE && MR && MW;
      case (state)
        IDLE: begin
          if (MR ^ MW) begin
            addr_q <= Addr;
            data_q <= W_MEM_OUT;
            state  <= MW ? WRITE : READ;
          end
        end
        WRITE: begin
`ifdef W_MEM_WRITE_THROUGH_EN
          W_MEM_IN <= data_q;
`endif
          state <= DONE;
        end
        READ: begin
          W_MEM_IN <= mem[addr_q];
          state    <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_w_mem_responder.sv
// tb_w_mem_responder: table-driven transactions plus directed corner sequences for w_mem_responder.
module tb_w_mem_responder;
  logic clk = 1'b0;
  logic reset, MR, MW;
  logic [7:0] Addr;
  logic [15:0] W_MEM_OUT, W_MEM_IN;
  logic Mem_Ready, Mem_Ack, Mem_Error;
  int total = 0, bad = 0;
`ifdef W_MEM_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  w_mem_responder #(.ADDR_W(8)) dut (
    .clk(clk), .reset(reset), .MR(MR), .MW(MW), .Addr(Addr), .W_MEM_OUT(W_MEM_OUT),
    .W_MEM_IN(W_MEM_IN), .Mem_Ready(Mem_Ready), .Mem_Ack(Mem_Ack), .Mem_Error(Mem_Error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd;
    logic [7:0]  addr;
    logic [15:0] data;
    logic [15:0] exp_q;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // one full accepted access; exp_q is W_MEM_IN expected in the Ack cycle
  task automatic xfer(input logic rd, input logic [7:0] a, input logic [15:0] d, input logic [15:0] exp_q);
    chk("ready_before", {15'b0, Mem_Ready}, 16'h1);
    MR = rd; MW = ~rd; Addr = a; W_MEM_OUT = d;
    step();
    MR = 1'b0; MW = 1'b0;
    chk("busy_ready", {15'b0, Mem_Ready}, 16'h0);
    chk("busy_ack", {15'b0, Mem_Ack}, 16'h0);
    step();
    chk("ack", {15'b0, Mem_Ack}, 16'h1);
    chk("ack_data", W_MEM_IN, exp_q);
    step();
    chk("ready_after", {15'b0, Mem_Ready}, 16'h1);
    chk("ack_gone", {15'b0, Mem_Ack}, 16'h0);
  endtask

  vec_t vt [11];

  initial begin
    vt[0]  = '{1'b0, 8'h12, 16'hBEEF, 16'h0000};
    vt[1]  = '{1'b1, 8'h12, 16'h0000, 16'hBEEF};
    vt[2]  = '{1'b0, 8'hFF, 16'h0F0F, 16'hBEEF};
    vt[3]  = '{1'b1, 8'hFF, 16'h0000, 16'h0F0F};
    vt[4]  = '{1'b0, 8'h01, 16'h5555, 16'h0F0F};
    vt[5]  = '{1'b1, 8'h01, 16'h0000, 16'h5555};
    vt[6]  = '{1'b0, 8'h00, 16'hA5A5, 16'h5555};
    vt[7]  = '{1'b1, 8'h00, 16'h0000, 16'hA5A5};
    vt[8]  = '{1'b0, 8'h12, 16'h1234, 16'hA5A5};
    vt[9]  = '{1'b1, 8'h12, 16'h0000, 16'h1234};
    vt[10] = '{1'b1, 8'hFF, 16'h0000, 16'h0F0F};
    reset = 1'b1; MR = 1'b0; MW = 1'b0; Addr = 8'h00; W_MEM_OUT = 16'h0000;
    step();
    chk("rst_q", W_MEM_IN, 16'h0000);
    chk("rst_ready", {15'b0, Mem_Ready}, 16'h1);
    chk("rst_ack", {15'b0, Mem_Ack}, 16'h0);
    chk("rst_err", {15'b0, Mem_Error}, 16'h0);
    reset = 1'b0;
    step();
    for (int i = 0; i < 11; i++)
      xfer(vt[i].rd, vt[i].addr, vt[i].data, (!vt[i].rd && WT) ? vt[i].data : vt[i].exp_q);

    // MR held through the Ack cycle: re-accepted in the following IDLE cycle
    MR = 1'b1; Addr = 8'hFF;
    step();
    Addr = 8'h00;
    step();
    chk("hold_ack1", {15'b0, Mem_Ack}, 16'h1);
    chk("hold_q1", W_MEM_IN, 16'h0F0F);
    step();
    chk("hold_idle", {15'b0, Mem_Ready}, 16'h1);
    step();
    MR = 1'b0;
    chk("hold_busy", {15'b0, Mem_Ready}, 16'h0);
    step();
    chk("hold_ack2", {15'b0, Mem_Ack}, 16'h1);
    chk("hold_q2", W_MEM_IN, 16'hA5A5);
    step();

    // MR and MW together: error pulse, no access
    xfer(1'b0, 8'h05, 16'h4242, WT ? 16'h4242 : 16'hA5A5);
    MR = 1'b1; MW = 1'b1; Addr = 8'h05; W_MEM_OUT = 16'hDEAD;
    step();
    MR = 1'b0; MW = 1'b0;
    chk("err_pulse", {15'b0, Mem_Error}, 16'h1);
    chk("err_ready", {15'b0, Mem_Ready}, 16'h1);
    chk("err_noack", {15'b0, Mem_Ack}, 16'h0);
    step();
    chk("err_end", {15'b0, Mem_Error}, 16'h0);
    chk("err_noack2", {15'b0, Mem_Ack}, 16'h0);
    xfer(1'b1, 8'h05, 16'h0000, 16'h4242);

    // reset during WRITE aborts the store
    xfer(1'b0, 8'h20, 16'hAAAA, WT ? 16'hAAAA : 16'h4242);
    MW = 1'b1; Addr = 8'h20; W_MEM_OUT = 16'h1234;
    step();
    MW = 1'b0;
    reset = 1'b1;
    #1;
    chk("mid_rst_q", W_MEM_IN, 16'h0000);
    chk("mid_rst_ready", {15'b0, Mem_Ready}, 16'h1);
    chk("mid_rst_ack", {15'b0, Mem_Ack}, 16'h0);
    chk("mid_rst_err", {15'b0, Mem_Error}, 16'h0);
    step();
    chk("mid_rst_ack2", {15'b0, Mem_Ack}, 16'h0);
    reset = 1'b0;
    step();
    xfer(1'b1, 8'h20, 16'h0000, 16'hAAAA);

    // inputs changed during WRITE are ignored
    xfer(1'b0, 8'h31, 16'h7777, WT ? 16'h7777 : 16'hAAAA);
    MW = 1'b1; Addr = 8'h30; W_MEM_OUT = 16'h1111;
    step();
    MW = 1'b0; Addr = 8'h31; W_MEM_OUT = 16'h2222;
    step();
    chk("chg_ack", {15'b0, Mem_Ack}, 16'h1);
    step();
    xfer(1'b1, 8'h30, 16'h0000, 16'h1111);
    xfer(1'b1, 8'h31, 16'h0000, 16'h7777);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
